vending_mcn: RTL and testbench

Coin-accumulating vending-machine controller: it sums coin values presented on a 4-bit input and dispenses one item once the credit reaches the fixed price of 15. It is a single-clock Moore/Mealy-registered FSM sitting between the coin-acceptor front end (which presents one decoded coin value per clock) and the dispense actuator. The current credit state is exported for status display and debug.

---
 rtl/vending_mcn_if.sv | 19 +
 rtl/vending_mcn.sv | 67 ++++++
 tb/tb_vending_mcn.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vending_mcn_if.sv
// Coin/dispense bus between acceptor, controller and actuator.
// data: coin value in; out: vend pulse; state: credit state.
interface vending_mcn_if;
  logic [3:0] data;
  logic       out;
  logic [1:0] state;

  modport master (
    output data,
    input  out,
    input  state
  );

  modport slave (
    input  data,
    output out,
    output state
  );
endinterface

// File: rtl/vending_mcn.sv
// Coin-accumulating vending controller, price 15, coins 5/10.
// Ports: clk, rst (async active-low), bus (data in, out/state regs).
module vending_mcn (
  input  logic         clk,
  input  logic         rst,
  vending_mcn_if.slave bus
);

  typedef enum logic [1:0] {
    S0  = 2'b00,
    S5  = 2'b01,
    S10 = 2'b10,
    SX  = 2'b11
  } state_t;

  state_t st;
  logic   vend;
  logic   five;
  logic   ten;

  // Undefined or unknown codes decode to neither coin.
  assign five = (bus.data == 4'd5);
  assign ten  = (bus.data == 4'd10);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= S0;
      vend <= 1'b0;
    end else begin
      vend <= 1'b0;
      case (st)
        S0: begin
          if (five) begin
            st <= S5;
          end else if (ten) begin
            st <= S10;
          end
        end
        S5: begin
          if (five) begin
            st <= S10;
          end else if (ten) begin
            st   <= S0;
            vend <= 1'b1;
          end
        end
        S10: begin
          if (five) begin
            st   <= S0;
            vend <= 1'b1;
          end else if (ten) begin
            // 20 paid, 5 carried over
            st   <= S5;
            vend <= 1'b1;
          end
        end
        default: begin
          st <= S0;
        end
      endcase
    end
  end

  assign bus.out   = vend;
  assign bus.state = st;

endmodule

// File: tb/tb_vending_mcn.sv
// Self-checking bench for vending_mcn.
// Vector table, corner sequences, random run vs credit model.
module tb_vending_mcn;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   credit;

  vending_mcn_if bus ();

  vending_mcn dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [1:0] exp_state;
    logic       exp_out;
  } vec_t;

  vec_t vecs [$];

  task automatic check(
    input string      name,
    input logic [1:0] exp_s,
    input logic       exp_o
  );
    checks++;
    if (bus.state !== exp_s || bus.out !== exp_o) begin
      errors++;
      $display("FAIL %s: state=%b out=%b, required state=%b out=%b",
               name, bus.state, bus.out, exp_s, exp_o);
    end
  endtask

  task automatic step(input logic [3:0] d);
    bus.data = d;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(
    input logic [3:0] d,
    input logic [1:0] s,
    input logic       o
  );
    vec_t v;
    v.data = d;
    v.exp_state = s;
    v.exp_out = o;
    vecs.push_back(v);
  endfunction

  // Model: credit in plain units, vend when it reaches 15.
  function automatic logic model_edge(input logic [3:0] d);
    int coin;
    coin = 0;
    if (d == 4'd5) coin = 5;
    if (d == 4'd10) coin = 10;
    credit = credit + coin;
    if (credit >= 15) begin
      credit = credit - 15;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    logic [3:0] d;
    logic       eo;
    logic [1:0] es;
    checks = 0;
    errors = 0;
    credit = 0;

    // Reset held with coins present
    rst = 1'b0;
    bus.data = 4'd5;
    #1;
    check("reset_t0", 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 2'b00, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_release", 2'b00, 1'b0);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      add(4'd5, 2'(((i + 1) % 3)), ((i % 3) == 2));
    end
    add(4'd10, 2'b10, 1'b0);
    add(4'd10, 2'b01, 1'b1);
    add(4'd0,  2'b01, 1'b0);
    add(4'd10, 2'b00, 1'b1);
    add(4'd5,  2'b01, 1'b0);
    add(4'd10, 2'b00, 1'b1);
    add(4'd10, 2'b10, 1'b0);
    add(4'd5,  2'b00, 1'b1);
    add(4'd5,  2'b01, 1'b0);
    add(4'd3,  2'b01, 1'b0);
    add(4'd7,  2'b01, 1'b0);
    add(4'd15, 2'b01, 1'b0);
    add(4'd0,  2'b01, 1'b0);
    add(4'd5,  2'b10, 1'b0);
    add(4'd10, 2'b01, 1'b1);
    add(4'd10, 2'b00, 1'b1);
    add(4'd0,  2'b00, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].data);
      check($sformatf("vec%0d", i),
            vecs[i].exp_state, vecs[i].exp_out);
    end

    // Async reset from S10, between edges
    step(4'd5);
    step(4'd5);
    check("reach_s10", 2'b10, 1'b0);
    bus.data = 4'd0;
    #3;
    rst = 1'b0;
    #1;
    check("async_s10", 2'b00, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Async reset while vend pulse is high
    step(4'd10);
    step(4'd5);
    check("vend_high", 2'b00, 1'b1);
    bus.data = 4'd0;
    #2;
    rst = 1'b0;
    #1;
    check("async_vend", 2'b00, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Random run against credit model
    credit = 0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: d = 4'd0;
        1, 2: d = 4'd5;
        3: d = 4'd10;
        default: d = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 29) == 0) begin
        bus.data = d;
        #2;
        rst = 1'b0;
        #1;
        credit = 0;
        check("rand_rst", 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
      end
      step(d);
      eo = model_edge(d);
      es = 2'(credit / 5);
      check($sformatf("rand%0d", i), es, eo);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
